cram_access_sched: RTL

Arbitrates a single byte-wide, single-port cart RAM between three requesters: the CPU/MBC path, the savestate CRAM copy engine, and the backup (save-file) load/store path. Grants at most one access per clk_sys cycle. Tracks outstanding reads through a tagged return pipeline and routes read data back to the issuing requester. Uses fixed priority, plus a starvation guard for the backup path.

---
 rtl/cram_sched_pkg.sv | 29 ++
 rtl/cram_rd_return.sv | 95 +++++++++
 rtl/cram_access_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cram_sched_pkg.sv
// cram_sched_pkg: shared types for the cart RAM access scheduler.
// Requester ids, read-return tag layout and default parameters.
package cram_sched_pkg;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_SS  = 2'd1,
        REQ_BK  = 2'd2
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

    localparam int DEF_AW         = 17;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_STARVE_MAX = 64;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, id: REQ_CPU};

    function automatic rd_tag_t mk_tag(input logic v, input req_id_e id);
        rd_tag_t t;
        t.valid = v;
        t.id    = id;
        return t;
    endfunction

endpackage

// File: rtl/cram_rd_return.sv
// cram_rd_return: tag shift pipeline matching the RAM read latency.
// Routes returning bytes to the requester that issued the read.
module cram_rd_return
    import cram_sched_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  rd_tag_t    push_tag,
    input  logic [7:0] ram_rdata,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic       ss_rvalid,
    output logic [7:0] ss_rdata,
    output logic       bk_rvalid,
    output logic [7:0] bk_rdata
);

    rd_tag_t    tag_q [RD_LAT];
    rd_tag_t    tag_d [RD_LAT];
    rd_tag_t    exit_tag;
    logic [2:0] rvalid_q;
    logic [2:0] rvalid_d;
    logic [7:0] cpu_rdata_q;
    logic [7:0] cpu_rdata_d;
    logic [7:0] ss_rdata_q;
    logic [7:0] ss_rdata_d;
    logic [7:0] bk_rdata_q;
    logic [7:0] bk_rdata_d;

    // Advance tags one stage per cycle; a new read enters stage 0.
    always_comb begin
        tag_d[0] = push_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign exit_tag = tag_q[RD_LAT-1];

    // Capture the byte for the exiting tag's owner; rvalid follows a cycle later.
    always_comb begin
        rvalid_d    = 3'b000;
        cpu_rdata_d = cpu_rdata_q;
        ss_rdata_d  = ss_rdata_q;
        bk_rdata_d  = bk_rdata_q;
        if (exit_tag.valid) begin
            unique case (exit_tag.id)
                REQ_CPU: begin
                    rvalid_d[0] = 1'b1;
                    cpu_rdata_d = ram_rdata;
                end
                REQ_SS: begin
                    rvalid_d[1] = 1'b1;
                    ss_rdata_d  = ram_rdata;
                end
                REQ_BK: begin
                    rvalid_d[2] = 1'b1;
                    bk_rdata_d  = ram_rdata;
                end
                default: ;
            endcase
        end
    end

    // Pipeline and return registers; reset drops any read in flight.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
            rvalid_q    <= 3'b000;
            cpu_rdata_q <= 8'h00;
            ss_rdata_q  <= 8'h00;
            bk_rdata_q  <= 8'h00;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            rvalid_q    <= rvalid_d;
            cpu_rdata_q <= cpu_rdata_d;
            ss_rdata_q  <= ss_rdata_d;
            bk_rdata_q  <= bk_rdata_d;
        end
    end

    assign cpu_rvalid = rvalid_q[0];
    assign ss_rvalid  = rvalid_q[1];
    assign bk_rvalid  = rvalid_q[2];
    assign cpu_rdata  = cpu_rdata_q;
    assign ss_rdata   = ss_rdata_q;
    assign bk_rdata   = bk_rdata_q;

endmodule

// File: rtl/cram_access_sched.sv
// cram_access_sched: fixed-priority cart RAM arbiter with backup starvation guard.
// Optional per-requester grant statistics under CRAM_SCHED_STATS_EN.
module cram_access_sched
    import cram_sched_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          sleep_savestate,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    input  logic          ss_req,
    input  logic          ss_we,
    input  logic [AW-1:0] ss_addr,
    input  logic [7:0]    ss_wdata,
    output logic          ss_ack,
    output logic          ss_rvalid,
    output logic [7:0]    ss_rdata,
    input  logic          bk_req,
    input  logic          bk_we,
    input  logic [AW-1:0] bk_addr,
    input  logic [7:0]    bk_wdata,
    output logic          bk_ack,
    output logic          bk_rvalid,
    output logic [7:0]    bk_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
`ifdef CRAM_SCHED_STATS_EN
    ,
    output logic [2:0][15:0] stat_grants,
    output logic [15:0]      stat_forced
`endif
);

    localparam logic [7:0] SMAX = STARVE_MAX[7:0];

    logic          cpu_elig;
    logic          ss_elig;
    logic          forced_bk;
    logic [2:0]    gnt;
    req_id_e       gnt_id;
    logic          sel_we;
    rd_tag_t       push_tag;
    logic [7:0]    starve_q;
    logic [7:0]    starve_d;
    logic [AW-1:0] ram_addr_q;
    logic [AW-1:0] ram_addr_d;
    logic [7:0]    ram_wdata_q;
    logic [7:0]    ram_wdata_d;

    assign cpu_elig  = cpu_req & ~sleep_savestate;
    assign ss_elig   = ss_req & sleep_savestate;
    assign forced_bk = bk_req & (starve_q == SMAX);

    // Pick at most one requester: forced backup, then cpu, ss, backup.
    always_comb begin
        gnt    = 3'b000;
        gnt_id = REQ_CPU;
        if (!reset_n) begin
            gnt = 3'b000;
        end else if (forced_bk) begin
            gnt[REQ_BK] = 1'b1;
            gnt_id      = REQ_BK;
        end else if (cpu_elig) begin
            gnt[REQ_CPU] = 1'b1;
            gnt_id       = REQ_CPU;
        end else if (ss_elig) begin
            gnt[REQ_SS] = 1'b1;
            gnt_id      = REQ_SS;
        end else if (bk_req) begin
            gnt[REQ_BK] = 1'b1;
            gnt_id      = REQ_BK;
        end
    end

    assign cpu_ack = gnt[REQ_CPU];
    assign ss_ack  = gnt[REQ_SS];
    assign bk_ack  = gnt[REQ_BK];

    // Steer the granted request onto the RAM; idle keeps the last address.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        sel_we      = 1'b0;
        unique case (1'b1)
            gnt[REQ_CPU]: begin
                ram_addr_d  = cpu_addr;
                ram_wdata_d = cpu_wdata;
                sel_we      = cpu_we;
            end
            gnt[REQ_SS]: begin
                ram_addr_d  = ss_addr;
                ram_wdata_d = ss_wdata;
                sel_we      = ss_we;
            end
            gnt[REQ_BK]: begin
                ram_addr_d  = bk_addr;
                ram_wdata_d = bk_wdata;
                sel_we      = bk_we;
            end
            default: ;
        endcase
    end

    assign ram_addr  = ram_addr_d;
    assign ram_wdata = ram_wdata_d;
    assign ram_we    = sel_we;
    assign push_tag  = mk_tag((|gnt) & ~sel_we, gnt_id);

    // Count cycles a backup request waits, saturating at the force threshold.
    always_comb begin
        if (!bk_req || gnt[REQ_BK]) begin
            starve_d = 8'h00;
        end else if (starve_q != SMAX) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            starve_q    <= 8'h00;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'h00;
        end else begin
            starve_q    <= starve_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    cram_rd_return #(
        .RD_LAT (RD_LAT)
    ) u_rd_return (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .push_tag   (push_tag),
        .ram_rdata  (ram_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ss_rvalid  (ss_rvalid),
        .ss_rdata   (ss_rdata),
        .bk_rvalid  (bk_rvalid),
        .bk_rdata   (bk_rdata)
    );

`ifdef CRAM_SCHED_STATS_EN
    logic [2:0][15:0] stat_grants_q;
    logic [2:0][15:0] stat_grants_d;
    logic [15:0]      stat_forced_q;
    logic [15:0]      stat_forced_d;

    // Saturating grant counters per requester plus forced-backup count.
    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_forced_d = stat_forced_q;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i] && stat_grants_q[i] != 16'hFFFF) begin
                stat_grants_d[i] = stat_grants_q[i] + 16'd1;
            end
        end
        if (forced_bk && gnt[REQ_BK] && stat_forced_q != 16'hFFFF) begin
            stat_forced_d = stat_forced_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            stat_grants_q <= '0;
            stat_forced_q <= 16'h0000;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_forced_q <= stat_forced_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_forced = stat_forced_q;
`endif

endmodule
